// File: rtl/synth_pkg.sv
// Shared encodings for the voice scheduler: slot states, FSM states and the
// MIDI rule that a zero-velocity note-on is really a note-off.
package synth_pkg;

  typedef enum logic [1:0] {
    V_FREE     = 2'd0,
    V_HELD     = 2'd1,
    V_RELEASED = 2'd2
  } voice_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_ISSUE = 2'd2,
    S_FLUSH = 2'd3
  } fsm_state_t;

  localparam logic [6:0] VEL_OFF = 7'd0;

  function automatic logic is_note_off(input logic on, input logic [6:0] vel);
    return !on || (vel == VEL_OFF);
  endfunction

endpackage

// File: rtl/voice_table.sv
// Per-slot voice storage: state, channel, note and saturating age, with one
// combinational read port, one write port and a global age-increment strobe.
module voice_table
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int AGE_W      = 8,
  parameter int IDX_W      = 4,
  parameter int CNT_W      = 5
) (
  input  logic               clk32,
  input  logic               rst_n,
  input  logic [IDX_W-1:0]   rd_idx,
  output voice_state_t       rd_state,
  output logic [3:0]         rd_channel,
  output logic [6:0]         rd_note,
  output logic [AGE_W-1:0]   rd_age,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  voice_state_t       wr_state,
  input  logic               wr_new,
  input  logic [3:0]         wr_channel,
  input  logic [6:0]         wr_note,
  input  logic               age_inc,
  output logic [CNT_W-1:0]   active_cnt
);

  voice_state_t     st   [NUM_VOICES];
  logic [AGE_W-1:0] age  [NUM_VOICES];
  logic [3:0]       chan [NUM_VOICES];
  logic [6:0]       nt   [NUM_VOICES];

  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (&a) ? a : a + AGE_W'(1);
  endfunction

  assign rd_state   = st[rd_idx];
  assign rd_channel = chan[rd_idx];
  assign rd_note    = nt[rd_idx];
  assign rd_age     = age[rd_idx];

  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        st[i]  <= V_FREE;
        age[i] <= '0;
      end
      active_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          st[i] <= wr_state;
          if (wr_new) age[i] <= '0;
        end else if (age_inc && (st[i] != V_FREE)) begin
          age[i] <= age_sat_inc(age[i]);
        end
      end
      // Held count tracks only transitions into and out of HELD.
      if (wr_en) begin
        if ((st[wr_idx] != V_HELD) && (wr_state == V_HELD))
          active_cnt <= active_cnt + CNT_W'(1);
        else if ((st[wr_idx] == V_HELD) && (wr_state != V_HELD))
          active_cnt <= active_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk32) begin
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (wr_en && wr_new && (wr_idx == IDX_W'(i))) begin
        chan[i] <= wr_channel;
        nt[i]   <= wr_note;
      end
    end
  end

endmodule

// File: rtl/voice_alloc.sv
// MIDI voice scheduler: maps note events to voice slots, steals the oldest
// voice when full, and issues one-cycle press/release pulses to the synth.
module voice_alloc
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 16,
  parameter int ADDR_W     = 8,
  parameter int AGE_W      = 8
) (
  input  logic                              clk32,
  input  logic                              rst_n,
  input  logic                              ev_valid,
  output logic                              ev_ready,
  input  logic                              ev_on,
  input  logic [6:0]                        ev_note,
  input  logic [6:0]                        ev_velocity,
  input  logic [3:0]                        ev_channel,
  input  logic                              panic,
  output logic                              note_pressed,
  output logic                              note_released,
  output logic [6:0]                        note,
  output logic [6:0]                        velocity,
  output logic [3:0]                        channel,
  output logic [ADDR_W-1:0]                 addr,
  output logic                              steal,
  output logic                              miss,
  output logic [$clog2(NUM_VOICES+1)-1:0]   active_cnt
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int CNT_W = $clog2(NUM_VOICES + 1);

  if (NUM_VOICES < 1 || NUM_VOICES > 128) begin : g_bad_voices
    $error("voice_alloc: NUM_VOICES must be in 1..128");
  end
  if (ADDR_W < IDX_W) begin : g_bad_addr
    $error("voice_alloc: ADDR_W too narrow for NUM_VOICES");
  end

  fsm_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last, accept;

  logic             off_p0;
  logic [6:0]       note_p0, vel_p0;
  logic [3:0]       chan_p0;

  logic             match_vld_p1, free_vld_p1, rel_vld_p1, old_vld_p1;
  logic [IDX_W-1:0] match_idx_p1, free_idx_p1, rel_idx_p1, old_idx_p1;
  logic [AGE_W-1:0] rel_age_p1, old_age_p1;
  logic [IDX_W-1:0] target;

  voice_state_t     rd_state;
  logic [3:0]       rd_channel;
  logic [6:0]       rd_note;
  logic [AGE_W-1:0] rd_age;
  logic             wr_en, wr_new, age_inc;
  logic [IDX_W-1:0] wr_idx;
  voice_state_t     wr_state;

  logic              pressed_d, released_d, steal_d, miss_d;
  logic [6:0]        note_d, vel_d;
  logic [3:0]        chan_d;
  logic [ADDR_W-1:0] addr_d;

  voice_table #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .IDX_W      (IDX_W),
    .CNT_W      (CNT_W)
  ) u_table (
    .clk32      (clk32),
    .rst_n      (rst_n),
    .rd_idx     (idx_q),
    .rd_state   (rd_state),
    .rd_channel (rd_channel),
    .rd_note    (rd_note),
    .rd_age     (rd_age),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_state   (wr_state),
    .wr_new     (wr_new),
    .wr_channel (chan_p0),
    .wr_note    (note_p0),
    .age_inc    (age_inc),
    .active_cnt (active_cnt)
  );

  assign ev_ready = (state_q == S_IDLE);
  assign last     = (idx_q == IDX_W'(NUM_VOICES - 1));
  // Preference order for a note-on: retrigger, free, oldest released, oldest held.
  assign target   = match_vld_p1 ? match_idx_p1 :
                    free_vld_p1  ? free_idx_p1  :
                    rel_vld_p1   ? rel_idx_p1   : old_idx_p1;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    accept     = 1'b0;
    wr_en      = 1'b0;
    wr_idx     = idx_q;
    wr_state   = V_FREE;
    wr_new     = 1'b0;
    age_inc    = 1'b0;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    steal_d    = 1'b0;
    miss_d     = 1'b0;
    note_d     = note;
    vel_d      = velocity;
    chan_d     = channel;
    addr_d     = addr;
    case (state_q)
      S_IDLE: begin
        if (panic) begin
          state_d = S_FLUSH;
          idx_d   = '0;
        end else if (ev_valid) begin
          accept  = 1'b1;
          state_d = S_SCAN;
          idx_d   = '0;
        end
      end
      S_SCAN: begin
        if (last) state_d = S_ISSUE;
        else      idx_d   = idx_q + IDX_W'(1);
      end
      S_ISSUE: begin
        state_d = S_IDLE;
        if (!off_p0) begin
          wr_en     = 1'b1;
          wr_idx    = target;
          wr_state  = V_HELD;
          wr_new    = 1'b1;
          age_inc   = 1'b1;
          pressed_d = 1'b1;
          steal_d   = !match_vld_p1 && !free_vld_p1 && !rel_vld_p1 && old_vld_p1;
          note_d    = note_p0;
          vel_d     = vel_p0;
          chan_d    = chan_p0;
          addr_d    = ADDR_W'(target);
        end else if (match_vld_p1) begin
          wr_en      = 1'b1;
          wr_idx     = match_idx_p1;
          wr_state   = V_RELEASED;
          released_d = 1'b1;
          note_d     = note_p0;
          vel_d      = vel_p0;
          chan_d     = chan_p0;
          addr_d     = ADDR_W'(match_idx_p1);
        end else begin
          miss_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if (last) state_d = S_IDLE;
        else      idx_d   = idx_q + IDX_W'(1);
        if (rd_state == V_HELD) begin
          wr_en      = 1'b1;
          wr_state   = V_RELEASED;
          released_d = 1'b1;
          note_d     = rd_note;
          vel_d      = '0;
          chan_d     = rd_channel;
          addr_d     = ADDR_W'(idx_q);
        end
      end
    endcase
  end

  // p0: event capture; p1: running scan winners, final after the last index
  always_ff @(posedge clk32) begin
    if (accept) begin
      off_p0       <= is_note_off(ev_on, ev_velocity);
      note_p0      <= ev_note;
      vel_p0       <= ev_velocity;
      chan_p0      <= ev_channel;
      match_vld_p1 <= 1'b0;
      free_vld_p1  <= 1'b0;
      rel_vld_p1   <= 1'b0;
      old_vld_p1   <= 1'b0;
    end else if (state_q == S_SCAN) begin
      if (!match_vld_p1 && (rd_state == V_HELD) &&
          (rd_channel == chan_p0) && (rd_note == note_p0)) begin
        match_vld_p1 <= 1'b1;
        match_idx_p1 <= idx_q;
      end
      if (!free_vld_p1 && (rd_state == V_FREE)) begin
        free_vld_p1 <= 1'b1;
        free_idx_p1 <= idx_q;
      end
      if ((rd_state == V_RELEASED) && (!rel_vld_p1 || (rd_age > rel_age_p1))) begin
        rel_vld_p1 <= 1'b1;
        rel_idx_p1 <= idx_q;
        rel_age_p1 <= rd_age;
      end
      if ((rd_state == V_HELD) && (!old_vld_p1 || (rd_age > old_age_p1))) begin
        old_vld_p1 <= 1'b1;
        old_idx_p1 <= idx_q;
        old_age_p1 <= rd_age;
      end
    end
  end

  // p2: registered synth control outputs
  always_ff @(posedge clk32 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      note_pressed  <= 1'b0;
      note_released <= 1'b0;
      steal         <= 1'b0;
      miss          <= 1'b0;
      note          <= '0;
      velocity      <= '0;
      channel       <= '0;
      addr          <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      note_pressed  <= pressed_d;
      note_released <= released_d;
      steal         <= steal_d;
      miss          <= miss_d;
      note          <= note_d;
      velocity      <= vel_d;
      channel       <= chan_d;
      addr          <= addr_d;
    end
  end

endmodule

// File: tb/tb_voice_alloc.sv
// Bench for voice_alloc with four voices: directed vector table, panic flush,
// reset abort, age saturation and random events against a slot-level model.
module tb_voice_alloc;

  localparam int NV      = 4;
  localparam int AGE_MAX = 255;
  localparam int FREE = 0, HELD = 1, REL = 2;

  logic       clk32 = 1'b0;
  logic       rst_n = 1'b0;
  logic       ev_valid = 1'b0, ev_on = 1'b0, panic = 1'b0;
  logic [6:0] ev_note = '0, ev_velocity = '0;
  logic [3:0] ev_channel = '0;
  logic       ev_ready, note_pressed, note_released, steal, miss;
  logic [6:0] note, velocity;
  logic [3:0] channel;
  logic [7:0] addr;
  logic [2:0] active_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  voice_alloc #(.NUM_VOICES(NV), .ADDR_W(8), .AGE_W(8)) dut (
    .clk32(clk32), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_on(ev_on), .ev_note(ev_note), .ev_velocity(ev_velocity),
    .ev_channel(ev_channel), .panic(panic), .note_pressed(note_pressed),
    .note_released(note_released), .note(note), .velocity(velocity),
    .channel(channel), .addr(addr), .steal(steal), .miss(miss),
    .active_cnt(active_cnt)
  );

  always #5 clk32 = ~clk32;

  typedef struct {
    int p, r, m, s, addr, note, vel, ch, cnt;
  } exp_t;

  typedef struct {
    bit rst;
    bit on;
    int note, vel, ch;
    int p, r, m, s, addr, cnt;
  } vec_t;

  int m_st [NV];
  int m_ch [NV];
  int m_note [NV];
  int m_age [NV];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NV; i++) begin
      m_st[i] = FREE; m_age[i] = 0; m_ch[i] = 0; m_note[i] = 0;
    end
  endfunction

  function automatic int model_held();
    int c = 0;
    for (int i = 0; i < NV; i++) if (m_st[i] == HELD) c++;
    return c;
  endfunction

  function automatic exp_t model_event(input bit on, input int n, input int v, input int c);
    exp_t e;
    int match, free, rel, old, tgt;
    e = '{default: 0};
    match = -1; free = -1; rel = -1; old = -1;
    for (int i = 0; i < NV; i++) begin
      if (match < 0 && m_st[i] == HELD && m_ch[i] == c && m_note[i] == n) match = i;
      if (free < 0 && m_st[i] == FREE) free = i;
      if (m_st[i] == REL && (rel < 0 || m_age[i] > m_age[rel])) rel = i;
      if (m_st[i] == HELD && (old < 0 || m_age[i] > m_age[old])) old = i;
    end
    if (on && v != 0) begin
      if (match >= 0)     tgt = match;
      else if (free >= 0) tgt = free;
      else if (rel >= 0)  tgt = rel;
      else                tgt = old;
      e.s = (match < 0 && free < 0 && rel < 0) ? 1 : 0;
      for (int i = 0; i < NV; i++)
        if (i != tgt && m_st[i] != FREE && m_age[i] < AGE_MAX) m_age[i]++;
      m_st[tgt] = HELD; m_age[tgt] = 0; m_ch[tgt] = c; m_note[tgt] = n;
      e.p = 1; e.addr = tgt; e.note = n; e.vel = v; e.ch = c;
    end else if (match >= 0) begin
      m_st[match] = REL;
      e.r = 1; e.addr = match; e.note = n; e.vel = v; e.ch = c;
    end else begin
      e.m = 1;
    end
    e.cnt = model_held();
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk32);
    @(negedge clk32);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Leaves time just after the edge on which the result pulse is registered.
  task automatic send_event(input bit on, input int n, input int v, input int c);
    int  waited = 0;
    bit  quiet  = 1'b1;
    @(negedge clk32);
    while (!ev_ready && waited < 20) begin
      @(negedge clk32);
      waited++;
    end
    if (!ev_ready) chk("ready_wait", 0, 1);
    ev_valid = 1'b1; ev_on = on;
    ev_note = 7'(n); ev_velocity = 7'(v); ev_channel = 4'(c);
    @(posedge clk32);
    #1;
    ev_valid = 1'b0;
    for (int k = 0; k <= NV; k++) begin
      if (k > 0) begin
        @(posedge clk32);
        #1;
      end
      if (note_pressed || note_released || miss || steal || ev_ready) quiet = 1'b0;
    end
    chk("quiet_scan", int'(quiet), 1);
    @(posedge clk32);
    #1;
    chk("ready_after_issue", int'(ev_ready), 1);
  endtask

  task automatic check_pulse(input string tag, input exp_t e);
    chk({tag, "_pulses"}, int'({note_pressed, note_released, miss, steal}),
        (e.p << 3) | (e.r << 2) | (e.m << 1) | e.s);
    if (e.p != 0 || e.r != 0) begin
      chk({tag, "_addr"}, int'(addr), e.addr);
      chk({tag, "_note"}, int'(note), e.note);
      chk({tag, "_vel"}, int'(velocity), e.vel);
      chk({tag, "_ch"}, int'(channel), e.ch);
    end
    chk({tag, "_cnt"}, int'(active_cnt), e.cnt);
  endtask

  task automatic run_event(input string tag, input bit on, input int n, input int v, input int c);
    exp_t e;
    e = model_event(on, n, v, c);
    send_event(on, n, v, c);
    check_pulse(tag, e);
  endtask

  task automatic do_panic(input string tag);
    int eh [NV];
    int en [NV];
    int ec [NV];
    for (int i = 0; i < NV; i++) begin
      eh[i] = (m_st[i] == HELD) ? 1 : 0;
      en[i] = m_note[i];
      ec[i] = m_ch[i];
      if (m_st[i] == HELD) m_st[i] = REL;
    end
    @(negedge clk32);
    panic = 1'b1;
    @(posedge clk32);
    #1;
    panic = 1'b0;
    chk({tag, "_busy"}, int'(ev_ready), 0);
    for (int k = 0; k < NV; k++) begin
      @(posedge clk32);
      #1;
      chk({tag, "_rel"}, int'({note_pressed, note_released}), eh[k]);
      if (eh[k] != 0) begin
        chk({tag, "_addr"}, int'(addr), k);
        chk({tag, "_note"}, int'(note), en[k]);
        chk({tag, "_ch"}, int'(channel), ec[k]);
        chk({tag, "_vel"}, int'(velocity), 0);
      end
    end
    chk({tag, "_cnt"}, int'(active_cnt), 0);
    chk({tag, "_ready"}, int'(ev_ready), 1);
  endtask

  vec_t tbl [17];

  initial begin
    exp_t e;
    bit   quiet;

    tbl[0]  = '{1, 1, 60, 100, 0,  1, 0, 0, 0, 0, 1};
    tbl[1]  = '{0, 1, 62,  90, 0,  1, 0, 0, 0, 1, 2};
    tbl[2]  = '{0, 1, 64,  80, 0,  1, 0, 0, 0, 2, 3};
    tbl[3]  = '{0, 1, 65,  70, 0,  1, 0, 0, 0, 3, 4};
    tbl[4]  = '{0, 1, 67,  60, 0,  1, 0, 0, 1, 0, 4};
    tbl[5]  = '{0, 0, 62,  64, 0,  0, 1, 0, 0, 1, 3};
    tbl[6]  = '{0, 1, 70,  50, 0,  1, 0, 0, 0, 1, 4};
    tbl[7]  = '{0, 0, 50,   0, 3,  0, 0, 1, 0, 0, 4};
    tbl[8]  = '{0, 1, 67,   0, 0,  0, 1, 0, 0, 0, 3};
    tbl[9]  = '{0, 1, 67,  80, 0,  1, 0, 0, 0, 0, 4};
    tbl[10] = '{0, 1, 70,  10, 0,  1, 0, 0, 0, 1, 4};
    tbl[11] = '{1, 1, 60, 100, 0,  1, 0, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 60,  30, 0,  0, 1, 0, 0, 0, 0};
    tbl[13] = '{0, 1, 72,  90, 0,  1, 0, 0, 0, 1, 1};
    tbl[14] = '{0, 0, 50,   0, 3,  0, 0, 1, 0, 0, 1};
    tbl[15] = '{0, 1, 60, 100, 0,  1, 0, 0, 0, 2, 2};
    tbl[16] = '{0, 1, 60,   0, 0,  0, 1, 0, 0, 2, 1};

    do_reset();
    chk("reset_pulses_cnt", int'({note_pressed, note_released, steal, miss, active_cnt}), 0);
    chk("reset_data", int'({addr, note, velocity, channel}), 0);
    chk("reset_ready", int'(ev_ready), 1);

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].rst) do_reset();
      send_event(tbl[i].on, tbl[i].note, tbl[i].vel, tbl[i].ch);
      e = '{p: tbl[i].p, r: tbl[i].r, m: tbl[i].m, s: tbl[i].s, addr: tbl[i].addr,
            note: tbl[i].note, vel: tbl[i].vel, ch: tbl[i].ch, cnt: tbl[i].cnt};
      check_pulse($sformatf("vec%0d", i), e);
    end

    // Reset asserted while an accepted event is still scanning.
    @(negedge clk32);
    ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd61; ev_velocity = 7'd99; ev_channel = 4'd0;
    @(posedge clk32);
    #1;
    ev_valid = 1'b0;
    @(posedge clk32);
    @(posedge clk32);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_pulses_cnt", int'({note_pressed, note_released, steal, miss, active_cnt}), 0);
    chk("abort_data", int'({addr, note, velocity, channel}), 0);
    @(negedge clk32);
    rst_n = 1'b1;
    model_reset();
    quiet = 1'b1;
    repeat (NV + 3) begin
      @(posedge clk32);
      #1;
      if (note_pressed || note_released || miss || steal) quiet = 1'b0;
    end
    chk("abort_no_pulse", int'(quiet), 1);
    chk("abort_ready", int'(ev_ready), 1);
    run_event("post_abort", 1, 33, 77, 5);
    chk("post_abort_addr0", int'(addr), 0);

    // Panic with all four voices held.
    do_reset();
    run_event("pf0", 1, 60, 100, 0);
    run_event("pf1", 1, 62, 100, 0);
    run_event("pf2", 1, 64, 100, 0);
    run_event("pf3", 1, 65, 100, 0);
    do_panic("panic_full");
    run_event("after_panic", 1, 40, 20, 1);

    // Ages saturate; three saturated slots tie and the lowest index is stolen.
    do_reset();
    run_event("sat_a", 1, 10, 50, 2);
    run_event("sat_b", 1, 11, 50, 2);
    run_event("sat_c", 1, 12, 50, 2);
    run_event("sat_d", 1, 13, 50, 2);
    run_event("sat_offa", 0, 10, 5, 2);
    run_event("sat_e", 1, 14, 50, 2);
    for (int i = 0; i < 300; i++) run_event("sat_retrig", 1, 13, 40, 2);
    run_event("sat_f", 1, 15, 60, 2);
    chk("sat_steal_addr", int'(addr), 0);
    chk("sat_steal_flag", int'(steal), 1);

    // Random traffic over a narrow note range to exercise matches and steals.
    do_reset();
    for (int i = 0; i < 150; i++) begin
      int r, n, c, v;
      r = int'($urandom_range(0, 99));
      n = 60 + int'($urandom_range(0, 5));
      c = int'($urandom_range(0, 1));
      v = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 127));
      if (r < 6) do_panic("rnd_panic");
      else       run_event("rnd", (r < 70), n, v, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/voice_alloc.md
Name: voice_alloc

Overview:
- Voice scheduler in front of the synth voice engine.
- Accepts MIDI note-on/off events and maps each (channel, note) pair to a voice slot address.
- Issues single-cycle note_pressed/note_released pulses with that address to the synth control port.
- Tracks slot occupancy and age; steals the oldest voice when all slots are busy.

Parameters:
- NUM_VOICES, 16: number of voice slots managed; must be ≤ 128.
- ADDR_W, 8: width of the slot address output.
- AGE_W, 8: width of the per-slot age counter; saturates at all-ones.

Ports:
- clk32  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ev_valid  in  1  event request
- ev_ready  out  1  block can accept an event; high only in IDLE
- ev_on  in  1  1 = note-on, 0 = note-off
- ev_note  in  7  MIDI note
- ev_velocity  in  7  MIDI velocity
- ev_channel  in  4  MIDI channel
- panic  in  1  release all held voices; level-sampled in IDLE
- note_pressed  out  1  one-cycle pulse to synth
- note_released  out  1  one-cycle pulse to synth
- note  out  7  note for the issued pulse
- velocity  out  7  velocity for the issued pulse
- channel  out  4  channel for the issued pulse
- addr  out  ADDR_W  voice slot, zero-extended index
- steal  out  1  one-cycle pulse, coincident with note_pressed, when a held voice was stolen
- miss  out  1  one-cycle pulse when a note-off matched no held voice
- active_cnt  out  $clog2(NUM_VOICES+1)  number of HELD slots

Behaviour:
- Reset (async assert, sync deassert) forces:
  - state = IDLE; every slot FREE with age 0.
  - All pulse outputs 0; note/velocity/channel/addr = 0; active_cnt = 0; ev_ready = 1.
  - Reset during SCAN or FLUSH aborts with no pulse.
- Slot state is one of FREE, HELD, RELEASED.
- An event is accepted on ev_valid && ev_ready and captured into internal registers.
- A note-on with ev_velocity == 0 is treated as a note-off.
- FSM states: IDLE, SCAN, ISSUE, FLUSH.
  - IDLE: panic = 1 has priority over ev_valid → FLUSH, index 0. Otherwise an accepted event → SCAN, index 0.
  - SCAN: one slot per cycle, index 0 .. NUM_VOICES-1, recording:
    - match: first HELD slot with equal channel and note;
    - free: first FREE slot;
    - rel: RELEASED slot with the largest age, lowest index on tie;
    - old: HELD slot with the largest age, lowest index on tie.
    - After the last index → ISSUE.
  - ISSUE (one cycle, registered outputs):
    - Note-on: target = match, else free, else rel, else old.
    - Pulse note_pressed with target addr and the captured note/velocity/channel.
    - steal = 1 only when the target came from old and is not a match.
    - Target becomes HELD with age 0. Every other non-FREE slot increments its age, saturating at 2^AGE_W-1.
    - Note-off with a match: pulse note_released at the match addr; slot becomes RELEASED with its age kept.
    - Note-off with no match: pulse miss only; table unchanged.
    - Then → IDLE.
  - FLUSH: one slot per cycle. Each HELD slot emits note_released with its stored note/channel, velocity 0, and becomes RELEASED. Non-HELD slots emit nothing. After the last index → IDLE.
- Latency: event accepted at cycle T → pulse visible at T+NUM_VOICES+1. ev_ready = 0 from T+1 until the cycle after ISSUE.
- active_cnt updates in the same cycle the slot state changes.
- The synth never reports end of release, so RELEASED slots are never returned to FREE. RELEASED slots are reused before HELD slots are stolen.
- note_pressed and note_released are never asserted together.

Decomposition:
- Shared package synth_pkg holds:
  - voice state encoding (FREE = 2'd0, HELD = 2'd1, RELEASED = 2'd2);
  - FSM state encoding;
  - the velocity-0-is-off rule as a constant-named function.
- One sub-module, voice_table: owns the per-slot state/channel/note/age registers, the indexed read port for SCAN/FLUSH, the single-slot write port, and the global age-increment strobe.
- voice_alloc keeps the FSM, the scan comparators and the output registers.

Test Plan (NUM_VOICES = 4):
- Reset release, then note-on ch0 note 60 vel 100 → after 5 cycles: note_pressed = 1, addr = 0, note = 60, velocity = 100, active_cnt = 1.
- Note-on notes 60, 62, 64, 65, then note-on 67 → 67 gets addr 0 (oldest held) with steal = 1; active_cnt stays 4.
- Note-on 60 (addr 0), note-off 60 → note_released addr 0; then note-on 72 → addr 1 (FREE preferred over RELEASED).
- Note-off ch3 note 50 with no holder → miss = 1, no release pulse, table unchanged. Note-on ch0 note 60 vel 0 after note 60 is held → note_released addr 0.
- Four notes held, panic = 1 → four note_released pulses on consecutive cycles, addr 0..3, velocity 0; active_cnt ends at 0.
- Drop rst_n mid-SCAN → all outputs 0 immediately; ev_ready = 1 after deassert; no pulse issued; the next note-on gets addr 0.
